logic_sweep_ctrl: RTL and testbench

- Self-test sequencer for the lab's 3-input gate block (inputs a, b, c; outputs x, y1).
- On start, drives all 8 input vectors in order, holds each for a programmable number of cycles, and samples the gate outputs.
- Compares the samples against golden truth tables and reports pass/fail, a per-vector failure mask and an error count.
- Sits between board buttons/LEDs and the gate instance.

---
 rtl/logic_sweep_pkg.sv | 14 +
 rtl/logic_step_timer.sv | 28 ++
 rtl/logic_sweep_ctrl.sv | 129 ++++++++++++
 tb/tb_logic_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_sweep_pkg.sv
// Shared types and constants for the 3-input gate self-test sequencer.
package logic_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam int         NUM_VEC = 8;
    localparam logic [7:0] GOLD_X  = 8'h95;  // x = (a&b) ^ ~c, indexed by {a,b,c}
    localparam logic [7:0] GOLD_Y  = 8'hC0;  // y1 = a&b

endpackage

// File: rtl/logic_step_timer.sv
// Per-vector hold timer: down-counts from STEP_CYCLES-1, tc high on the last hold cycle.
// tc is visible the cycle the count reaches zero; no backpressure, count stalls at zero.
module logic_step_timer #(
    parameter int STEP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int            CW   = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LOAD = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= LOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/logic_sweep_ctrl.sv
// Drives all 8 {a,b,c} vectors for STEP_CYCLES each, samples x/y1 on the last hold cycle.
// done rises 8*STEP_CYCLES+1 cycles after start; no backpressure, abort cancels at once.
module logic_sweep_ctrl
    import logic_sweep_pkg::*;
#(
    parameter int         STEP_CYCLES = 4,
    parameter logic [7:0] EXP_X       = GOLD_X,
    parameter logic [7:0] EXP_Y       = GOLD_Y
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 x_i,
    input  logic                 y_i,
    output logic                 a_o,
    output logic                 b_o,
    output logic                 c_o,
    output logic [2:0]           vec_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_VEC-1:0]   fail_mask,
    output logic [3:0]           err_cnt
);

    localparam logic [2:0] LAST_VEC = 3'(NUM_VEC - 1);

    sweep_state_t state, state_nx;
    logic         go, clear, sample, tmr_en, tmr_clr, tc, mis;

    logic_step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .en  (tmr_en),
        .tc  (tc)
    );

    assign mis = (x_i != EXP_X[vec_idx]) || (y_i != EXP_Y[vec_idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // abort outranks both start and the end-of-step compare
    always_comb begin
        state_nx = state;
        go       = 1'b0;
        clear    = 1'b0;
        sample   = 1'b0;
        tmr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = APPLY;
                    go       = 1'b1;
                end
            end
            APPLY: begin
                if (abort) begin
                    state_nx = IDLE;
                    clear    = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                    if (tc) begin
                        sample = 1'b1;
                        if (vec_idx == LAST_VEC) begin
                            state_nx = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (abort) begin
                    state_nx = IDLE;
                    clear    = 1'b1;
                end else if (start) begin
                    state_nx = APPLY;
                    go       = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                clear    = 1'b1;
            end
        endcase
        tmr_clr = go || clear || (sample && (vec_idx != LAST_VEC));
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vec_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_cnt   <= '0;
        end else if (go) begin
            vec_idx   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_cnt   <= '0;
        end else if (sample) begin
            if (mis) begin
                fail_mask[vec_idx] <= 1'b1;
                err_cnt            <= err_cnt + 4'd1;
            end
            if (vec_idx == LAST_VEC) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (fail_mask == '0) && !mis;
            end else begin
                vec_idx <= vec_idx + 3'd1;
            end
        end
    end

    assign {a_o, b_o, c_o} = vec_idx;

endmodule

// File: tb/tb_logic_sweep_ctrl.sv
// Bench for logic_sweep_ctrl with a behavioural gate model and per-vector fault injection.
module tb_logic_sweep_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic       x_i, y_i;
    logic       a_o, b_o, c_o, busy, done, pass;
    logic [2:0] vec_idx;
    logic [7:0] fail_mask;
    logic [3:0] err_cnt;
    logic [7:0] fx, fy;
    logic [2:0] drv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Gate block model; a set bit in fx/fy corrupts that vector's output
    assign drv = {a_o, b_o, c_o};
    assign x_i = ((a_o & b_o) ^ ~c_o) ^ fx[drv];
    assign y_i = (a_o & b_o) ^ fy[drv];

    logic_sweep_ctrl #(.STEP_CYCLES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .x_i       (x_i),
        .y_i       (y_i),
        .a_o       (a_o),
        .b_o       (b_o),
        .c_o       (c_o),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .err_cnt   (err_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected failure mask from the truth tables: a vector fails when the
    // observed gate output differs from the golden table bit.
    function automatic logic [7:0] model_mask(input logic [7:0] fxm, input logic [7:0] fym);
        logic [7:0] gx, gy, m;
        logic [2:0] v;
        logic       ox, oy;
        gx = 8'h95;
        gy = 8'hC0;
        m  = '0;
        for (int k = 0; k < 8; k++) begin
            v    = k[2:0];
            ox   = ((v[2] & v[1]) ^ ~v[0]) ^ fxm[k];
            oy   = (v[2] & v[1]) ^ fym[k];
            m[k] = (ox != gx[k]) || (oy != gy[k]);
        end
        return m;
    endfunction

    task automatic check_idle(input string tag);
        logic [20:0] obs;
        obs = {busy, done, pass, a_o, b_o, c_o, vec_idx, fail_mask, err_cnt};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s idle: busy=%b done=%b pass=%b abc=%b vec=%0d mask=%h err=%0d, required all zero",
                     tag, busy, done, pass, drv, vec_idx, fail_mask, err_cnt);
        end
    endtask

    // Full sweep from IDLE or DONE: checks the vector timeline every cycle,
    // then the result registers. poke5 re-pulses start during vector 5.
    task automatic run_sweep(input logic [7:0] fxi, input logic [7:0] fyi, input bit poke5, input string tag);
        logic [7:0] m;
        int         v;
        fx = fxi;
        fy = fyi;
        m  = model_mask(fxi, fyi);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 8 * S; j++) begin
            v = j / S;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || vec_idx !== 3'(v) || drv !== 3'(v)) begin
                errors++;
                $display("FAIL %s step %0d: busy=%b done=%b vec=%0d abc=%b, required busy=1 done=0 vec=%0d",
                         tag, j, busy, done, vec_idx, drv, v);
            end
            if (poke5 && j == 5 * S + 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || vec_idx !== 3'd7 || drv !== 3'd7) begin
            errors++;
            $display("FAIL %s end: done=%b busy=%b vec=%0d abc=%b, required done=1 busy=0 vec=7 abc=111",
                     tag, done, busy, vec_idx, drv);
        end
        checks++;
        if (fail_mask !== m || err_cnt !== 4'($countones(m)) || pass !== (m == 8'h00)) begin
            errors++;
            $display("FAIL %s result: mask=%h err=%0d pass=%b, required mask=%h err=%0d pass=%b",
                     tag, fail_mask, err_cnt, pass, m, $countones(m), (m == 8'h00));
        end
        tick();
        checks++;
        if (done !== 1'b1 || fail_mask !== m || drv !== 3'd7) begin
            errors++;
            $display("FAIL %s hold: done=%b mask=%h abc=%b, required done=1 mask=%h abc=111",
                     tag, done, fail_mask, drv, m);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("reset_release");
    endtask

    task automatic test_sweeps;
        run_sweep(8'h00, 8'h00, 1'b0, "golden");
        run_sweep(8'h00, 8'hC0, 1'b0, "y_stuck0");
        checks++;
        if (fail_mask !== 8'hC0 || err_cnt !== 4'd2) begin
            errors++;
            $display("FAIL y_stuck0_plan: mask=%h err=%0d, required mask=c0 err=2", fail_mask, err_cnt);
        end
        run_sweep(8'hFF, 8'h00, 1'b0, "x_invert");
        checks++;
        if (fail_mask !== 8'hFF || err_cnt !== 4'd8 || pass !== 1'b0) begin
            errors++;
            $display("FAIL x_invert_plan: mask=%h err=%0d pass=%b, required mask=ff err=8 pass=0",
                     fail_mask, err_cnt, pass);
        end
    endtask

    task automatic test_abort;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fx = 8'h01;
        fy = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3 * S + 1) tick();
        checks++;
        if (vec_idx !== 3'd3 || fail_mask !== 8'h01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: vec=%0d mask=%h busy=%b, required vec=3 mask=01 busy=1",
                     vec_idx, fail_mask, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_apply");
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort_idle");
        tick();
        check_idle("start_abort_idle_after");
    endtask

    task automatic test_back_to_back;
        run_sweep(8'h80, 8'h00, 1'b1, "restart_ignored");
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || vec_idx !== 3'd0 ||
            fail_mask !== 8'h00 || err_cnt !== 4'd0) begin
            errors++;
            $display("FAIL restart_from_done: busy=%b done=%b pass=%b vec=%0d mask=%h err=%0d, required 1 0 0 0 00 0",
                     busy, done, pass, vec_idx, fail_mask, err_cnt);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_restart");
        run_sweep(8'h00, 8'h08, 1'b0, "pre_done_clash");
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("done_start_abort");
    endtask

    task automatic test_rst_mid;
        fx = 8'h00;
        fy = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6 * S + 2) tick();
        checks++;
        if (vec_idx !== 3'd6) begin
            errors++;
            $display("FAIL rst_mid_pre: vec=%0d, required 6", vec_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_mid");
        run_sweep(8'h00, 8'h00, 1'b0, "post_rst");
    endtask

    task automatic test_random;
        logic [7:0] rx, ry;
        for (int i = 0; i < 8; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            if (i % 3 == 0) rx = rx & 8'($urandom);
            run_sweep(rx, ry, ($urandom_range(0, 1) == 1), "random");
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        fx    = 8'h00;
        fy    = 8'h00;
        test_reset();
        test_sweeps();
        test_abort();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
